// File: rtl/ctrl_pkg.sv
// Shared encodings for the control/issue unit: MIPS opcode/funct values,
// ALU_Control codes, the FSM state type and the decoded control bundle.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_NOR = 3'b100,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEM
   } state_t;

   // reg_write/branch/jump are "intent" bits; the FSM decides the cycle they fire.
   typedef struct packed {
      logic    mem_to_reg;
      logic    branch;
      logic    alu_src_b;
      logic    reg_write;
      logic    reg_dst;
      logic    jump;
      logic    is_load;
      logic    is_store;
      alu_op_t alu_ctrl;
   } ctrl_t;

endpackage

// File: rtl/ctrl_issue_if.sv
// Instruction-fetch and data-memory handshake bundle of the control/issue unit.
// master = the issue unit, slave = instruction/data memory side.
interface ctrl_issue_if;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic        mem_r;
   logic        mem_w;
   logic        mem_ack;

   modport master (
      input  inst, inst_valid, mem_ack,
      output inst_ready, mem_r, mem_w
   );

   modport slave (
      output inst, inst_valid, mem_ack,
      input  inst_ready, mem_r, mem_w
   );
endinterface

// File: rtl/inst_decode.sv
// Combinational MIPS decoder: opcode/funct to control bundle plus an illegal flag.
// Illegal encodings decode to an all-zero bundle, i.e. a NOP.
module inst_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output ctrl_t      ctrl,
   output logic       illegal
);

   // NOTE: every output gets a default before the case; a path that left one
   // unassigned would infer a latch.
   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      case (op)
         OP_RTYPE: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            case (funct)
               FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
               FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
               FN_AND:  ctrl.alu_ctrl = ALU_AND;
               FN_OR:   ctrl.alu_ctrl = ALU_OR;
               FN_NOR:  ctrl.alu_ctrl = ALU_NOR;
               FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
               default: begin
                  ctrl    = '0;
                  illegal = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            ctrl.alu_src_b  = 1'b1;
            ctrl.alu_ctrl   = ALU_ADD;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.is_load    = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src_b = 1'b1;
            ctrl.alu_ctrl  = ALU_ADD;
            ctrl.is_store  = 1'b1;
         end
         OP_ADDI: begin
            ctrl.alu_src_b = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctrl  = ALU_ADD;
         end
         OP_SLTI: begin
            ctrl.alu_src_b = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctrl  = ALU_SLT;
         end
         OP_BEQ: begin
            ctrl.branch   = 1'b1;
            ctrl.alu_ctrl = ALU_SUB;
         end
         OP_J: begin
            ctrl.jump     = 1'b1;
            ctrl.alu_ctrl = ALU_AND;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_issue.sv
// Multi-cycle control/issue unit for Data_path: FETCH -> EXEC [-> MEM] -> FETCH,
// with registered decode, memory timeout, sticky error and retired counter.
module ctrl_issue
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   ctrl_issue_if.master     bus,
   output logic             MemtoReg,
   output logic             Branch,
   output logic             ALUSrc_B,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             Jump,
   output logic [2:0]       ALU_Control,
   output logic [25:0]      inst_field,
   output logic             pc_en,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

   state_t            state_q, state_d;
   ctrl_t             dec_ctrl, ctrl_q;
   logic              dec_illegal;
   logic [25:0]       field_q;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              err_q;
   logic [CNT_W-1:0]  retired_q;
   logic              accept, set_err;
   logic              inst_ready_c, mem_r_c, mem_w_c;

   inst_decode u_decode (
      .op      (bus.inst[31:26]),
      .funct   (bus.inst[5:0]),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   always_comb begin
      state_d      = state_q;
      to_cnt_d     = to_cnt_q;
      inst_ready_c = 1'b0;
      mem_r_c      = 1'b0;
      mem_w_c      = 1'b0;
      pc_en        = 1'b0;
      RegWrite     = 1'b0;
      Branch       = 1'b0;
      Jump         = 1'b0;
      accept       = 1'b0;
      set_err      = 1'b0;
      case (state_q)
         ST_FETCH: begin
            inst_ready_c = 1'b1;
            if (bus.inst_valid) begin
               accept  = 1'b1;
               set_err = dec_illegal;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (ctrl_q.is_load || ctrl_q.is_store) begin
               mem_r_c  = ctrl_q.is_load;
               mem_w_c  = ctrl_q.is_store;
               to_cnt_d = '0;
               state_d  = ST_MEM;
            end else begin
               pc_en    = 1'b1;
               RegWrite = ctrl_q.reg_write;
               Branch   = ctrl_q.branch;
               Jump     = ctrl_q.jump;
               state_d  = ST_FETCH;
            end
         end
         ST_MEM: begin
            mem_r_c = ctrl_q.is_load;
            mem_w_c = ctrl_q.is_store;
            // An ack arriving on the timeout cycle still completes the access.
            if (bus.mem_ack) begin
               pc_en    = 1'b1;
               RegWrite = ctrl_q.reg_write;
               state_d  = ST_FETCH;
            end else if (to_cnt_q == TO_W'(MEM_TIMEOUT)) begin
               pc_en   = 1'b1;
               set_err = 1'b1;
               state_d = ST_FETCH;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         ctrl_q    <= '0;
         field_q   <= '0;
         to_cnt_q  <= '0;
         err_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
         if (accept) begin
            ctrl_q  <= dec_ctrl;
            field_q <= bus.inst[25:0];
         end
         if (set_err) err_q <= 1'b1;
         if (pc_en) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign bus.inst_ready = inst_ready_c;
   assign bus.mem_r      = mem_r_c;
   assign bus.mem_w      = mem_w_c;
   assign MemtoReg       = ctrl_q.mem_to_reg;
   assign ALUSrc_B       = ctrl_q.alu_src_b;
   assign RegDst         = ctrl_q.reg_dst;
   assign ALU_Control    = ctrl_q.alu_ctrl;
   assign inst_field     = field_q;
   assign err            = err_q;
   assign retired        = retired_q;

endmodule

// File: tb/tb_ctrl_issue.sv
// Randomized self-checking bench for ctrl_issue against an instruction-level
// reference model (decode table, commit timing, retired count, sticky error).
module tb_ctrl_issue;

   localparam int TO = 15;
   localparam int CW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ctrl_issue_if bus ();

   logic          MemtoReg, Branch, ALUSrc_B, RegWrite, RegDst, Jump, pc_en, err;
   logic [2:0]    ALU_Control;
   logic [25:0]   inst_field;
   logic [CW-1:0] retired;

   ctrl_issue #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .MemtoReg    (MemtoReg),
      .Branch      (Branch),
      .ALUSrc_B    (ALUSrc_B),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .Jump        (Jump),
      .ALU_Control (ALU_Control),
      .inst_field  (inst_field),
      .pc_en       (pc_en),
      .err         (err),
      .retired     (retired)
   );

   int unsigned   n_checks = 0;
   int unsigned   n_errors = 0;
   logic [31:0]   exp_retired = '0;
   logic          exp_err = 1'b0;
   logic [5:0]    fn_tab [6];

   typedef struct packed {
      logic       legal;
      logic       is_lw;
      logic       is_sw;
      logic [2:0] alu;
      logic       m2r;
      logic       src_b;
      logic       dst;
      logic       wr;
      logic       br;
      logic       jmp;
   } exp_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Instruction-level semantics straight from the MIPS control table.
   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      e = '0;
      e.legal = 1'b1;
      case (w[31:26])
         6'h00: begin
            e.dst = 1'b1;
            e.wr  = 1'b1;
            case (w[5:0])
               6'h20:   e.alu = 3'b010;
               6'h22:   e.alu = 3'b110;
               6'h24:   e.alu = 3'b000;
               6'h25:   e.alu = 3'b001;
               6'h27:   e.alu = 3'b100;
               6'h2a:   e.alu = 3'b111;
               default: e = '0;
            endcase
         end
         6'h23: begin e.is_lw = 1'b1; e.src_b = 1'b1; e.alu = 3'b010; e.m2r = 1'b1; e.wr = 1'b1; end
         6'h2b: begin e.is_sw = 1'b1; e.src_b = 1'b1; e.alu = 3'b010; end
         6'h08: begin e.src_b = 1'b1; e.wr = 1'b1; e.alu = 3'b010; end
         6'h0a: begin e.src_b = 1'b1; e.wr = 1'b1; e.alu = 3'b111; end
         6'h04: begin e.br = 1'b1; e.alu = 3'b110; end
         6'h02: begin e.jmp = 1'b1; e.alu = 3'b000; end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic check_muxes(input string tag, input exp_t e, input logic [31:0] w);
      check({tag, ".ALU_Control"}, 32'(ALU_Control), 32'(e.alu));
      check({tag, ".MemtoReg"}, 32'(MemtoReg), 32'(e.m2r));
      check({tag, ".ALUSrc_B"}, 32'(ALUSrc_B), 32'(e.src_b));
      check({tag, ".RegDst"}, 32'(RegDst), 32'(e.dst));
      check({tag, ".inst_field"}, 32'(inst_field), 32'(w[25:0]));
   endtask

   // Issue one instruction starting at a FETCH-cycle negedge; ack_at is the
   // MEM cycle (1-based) carrying mem_ack, 0 for never.
   task automatic run_inst(input logic [31:0] w, input int ack_at);
      exp_t e;
      bit   done;
      e = model(w);
      check("fetch.inst_ready", 32'(bus.inst_ready), 32'd1);
      bus.inst       = w;
      bus.inst_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.inst       = $urandom;
      bus.inst_valid = 1'($urandom_range(0, 1));
      bus.mem_ack    = 1'($urandom_range(0, 1));
      #1;
      check("exec.inst_ready", 32'(bus.inst_ready), 32'd0);
      if (e.is_lw || e.is_sw) begin
         check("exec.pc_en", 32'(pc_en), 32'd0);
         check("exec.RegWrite", 32'(RegWrite), 32'd0);
         check("exec.mem_r", 32'(bus.mem_r), 32'(e.is_lw));
         check("exec.mem_w", 32'(bus.mem_w), 32'(e.is_sw));
         done = 1'b0;
         for (int k = 1; k <= TO + 1 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.inst       = $urandom;
            bus.inst_valid = 1'($urandom_range(0, 1));
            bus.mem_ack    = (k == ack_at);
            #1;
            check("mem.mem_r", 32'(bus.mem_r), 32'(e.is_lw));
            check("mem.mem_w", 32'(bus.mem_w), 32'(e.is_sw));
            if (k == ack_at) begin
               check("ack.pc_en", 32'(pc_en), 32'd1);
               check("ack.RegWrite", 32'(RegWrite), 32'(e.is_lw));
               check("ack.Branch", 32'(Branch), 32'd0);
               check("ack.Jump", 32'(Jump), 32'd0);
               check_muxes("ack", e, w);
               done = 1'b1;
            end else if (k == TO + 1) begin
               check("timeout.pc_en", 32'(pc_en), 32'd1);
               check("timeout.RegWrite", 32'(RegWrite), 32'd0);
               exp_err = 1'b1;
               done = 1'b1;
            end else begin
               check("wait.pc_en", 32'(pc_en), 32'd0);
               check("wait.RegWrite", 32'(RegWrite), 32'd0);
            end
         end
      end else begin
         check("exec.pc_en", 32'(pc_en), 32'd1);
         check("exec.RegWrite", 32'(RegWrite), 32'(e.wr));
         check("exec.Branch", 32'(Branch), 32'(e.br));
         check("exec.Jump", 32'(Jump), 32'(e.jmp));
         check("exec.mem_r", 32'(bus.mem_r), 32'd0);
         check("exec.mem_w", 32'(bus.mem_w), 32'd0);
         if (e.legal) check_muxes("exec", e, w);
         else exp_err = 1'b1;
      end
      exp_retired++;
      @(posedge clk);
      @(negedge clk);
      bus.mem_ack    = 1'b0;
      bus.inst_valid = 1'b0;
      #1;
      check("post.pc_en", 32'(pc_en), 32'd0);
      check("post.RegWrite", 32'(RegWrite), 32'd0);
      check("post.retired", retired, exp_retired);
      check("post.err", 32'(err), 32'(exp_err));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] w;
      int          ack_at;

      fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
      fn_tab[3] = 6'h25; fn_tab[4] = 6'h27; fn_tab[5] = 6'h2a;

      bus.inst       = '0;
      bus.inst_valid = 1'b0;
      bus.mem_ack    = 1'b0;
      rst            = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.inst_ready", 32'(bus.inst_ready), 32'd1);
      check("rst.pc_en", 32'(pc_en), 32'd0);
      check("rst.mem_r", 32'(bus.mem_r), 32'd0);
      check("rst.mem_w", 32'(bus.mem_w), 32'd0);
      check("rst.RegWrite", 32'(RegWrite), 32'd0);
      check("rst.ALU_Control", 32'(ALU_Control), 32'd0);
      check("rst.err", 32'(err), 32'd0);
      check("rst.retired", retired, 32'd0);
      rst = 1'b0;

      // Directed sequence from the test plan.
      run_inst(32'h00000827, 0);
      run_inst(32'h8C05000E, 3);
      run_inst(32'h1045FFFB, 0);
      run_inst(32'h08000000, 0);
      run_inst(32'hFC000000, 0);
      run_inst(32'h00000827, 0);

      // Reset in the second MEM cycle of a lw; a late ack must do nothing.
      bus.inst       = 32'h8C05000E;
      bus.inst_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.inst_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("rstmem.mem_r_before", 32'(bus.mem_r), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_retired = '0;
      exp_err     = 1'b0;
      #1;
      check("rstmem.mem_r", 32'(bus.mem_r), 32'd0);
      check("rstmem.inst_ready", 32'(bus.inst_ready), 32'd1);
      check("rstmem.retired", retired, exp_retired);
      check("rstmem.err", 32'(err), 32'(exp_err));
      bus.mem_ack = 1'b1;
      #1;
      check("rstmem.ack_RegWrite", 32'(RegWrite), 32'd0);
      check("rstmem.ack_pc_en", 32'(pc_en), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check("rstmem.retired_after", retired, exp_retired);

      // sw with no ack at all.
      run_inst(32'hAC05000E, 0);

      // Randomized mix, including illegal encodings and varied ack delays.
      for (int n = 0; n < 250; n++) begin
         w = $urandom;
         case ($urandom_range(0, 9))
            0, 1: begin w[31:26] = 6'h00; w[5:0] = fn_tab[$urandom_range(0, 5)]; end
            2: w[31:26] = 6'h23;
            3: w[31:26] = 6'h2b;
            4: w[31:26] = 6'h08;
            5: w[31:26] = 6'h0a;
            6: w[31:26] = 6'h04;
            7: w[31:26] = 6'h02;
            8: w[31:26] = 6'h00;
            default: ;
         endcase
         ack_at = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO));
         run_inst(w, ack_at);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
